subwidth_packer: RTL and testbench

- Downstream consumer of the subwidth block's output group: bus4a [0:3], bus4b [7:4], bus1a, bus1b [0:0] and busdef [DEFA:DEFB].
- Captures one snapshot of the group per valid/ready handshake and packs it into a single flat word.
- Buffers packed words in a small FIFO and streams them out on a valid/ready interface.
- Also provides an occupancy count and a sticky drop flag for debug.

---
 rtl/subwidth_packer.sv | 114 +++++++++++
 tb/tb_subwidth_packer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/subwidth_packer.sv
// subwidth_packer
//   Captures one snapshot of the subwidth output group per valid/ready
//   handshake, packs it into a flat word and queues it in a small FIFO that
//   streams out on a valid/ready interface.
//
// Ports:
//   clk          rising-edge clock
//   reset_l      asynchronous active-low reset
//   in_valid     snapshot on bus4a/bus4b/bus1a/bus1b/busdef is valid
//   in_ready     packer can accept a snapshot (FIFO not full)
//   bus4a        [0:3] ascending nibble
//   bus4b        [7:4] descending nibble
//   bus1a        scalar bit
//   bus1b        [0:0] one-bit vector
//   busdef       [DEFA:DEFB] define-sized field
//   clr_drop     synchronous clear of drop_sticky
//   out_valid    FIFO head valid
//   out_ready    consumer accepts head
//   out_data     packed head word
//   count        FIFO occupancy, 0..DEPTH
//   drop_sticky  a snapshot was offered while full
module subwidth_packer #(
    parameter int DEFA  = 7,
    parameter int DEFB  = 0,
    parameter int DEPTH = 4,
    localparam int BW   = 1 + DEFA - DEFB,
    localparam int W    = 10 + BW,
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset_l,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [0:3]       bus4a,
    input  logic [7:4]       bus4b,
    input  logic             bus1a,
    input  logic [0:0]       bus1b,
    input  logic [DEFA:DEFB] busdef,
    input  logic             clr_drop,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data,
    output logic [CW-1:0]    count,
    output logic             drop_sticky
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [W-1:0]  packed_word;
    logic          push;
    logic          pop;
    logic          drop;

    // Concatenation follows each declared range left to right, so bus4a[0]
    // lands at the MSB and busdef[DEFB] at bit 0 without any reversal.
    assign packed_word = {bus4a, bus4b, bus1a, bus1b, busdef};

    // Both flags come from registered count only; a pop never frees a slot
    // for a push in the same cycle.
    assign in_ready  = (count != FULL);
    assign out_valid = (count != '0);
    assign out_data  = mem[rd_ptr];

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;
    assign drop = in_valid && !in_ready;

    // Storage is reset too so out_data reads zero straight out of reset.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wr_ptr] <= packed_word;
        end
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    // Set has priority over clear.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            drop_sticky <= 1'b0;
        end else if (drop) begin
            drop_sticky <= 1'b1;
        end else if (clr_drop) begin
            drop_sticky <= 1'b0;
        end
    end

endmodule

// File: tb/tb_subwidth_packer.sv
// tb_subwidth_packer
//   Directed bench for subwidth_packer with DEFA=7, DEFB=0, DEPTH=4
//   (W=18, CW=3). Inputs change 1ns after each rising edge; outputs are
//   checked at the same point, away from the active edge.
module tb_subwidth_packer;

    logic        clk;
    logic        reset_l;
    logic        in_valid;
    logic        in_ready;
    logic [0:3]  bus4a;
    logic [7:4]  bus4b;
    logic        bus1a;
    logic [0:0]  bus1b;
    logic [7:0]  busdef;
    logic        clr_drop;
    logic        out_valid;
    logic        out_ready;
    logic [17:0] out_data;
    logic [2:0]  count;
    logic        drop_sticky;

    int checks;
    int passed;

    subwidth_packer #(.DEFA(7), .DEFB(0), .DEPTH(4)) dut (
        .clk         (clk),
        .reset_l     (reset_l),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .bus4a       (bus4a),
        .bus4b       (bus4b),
        .bus1a       (bus1a),
        .bus1b       (bus1b),
        .busdef      (busdef),
        .clr_drop    (clr_drop),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .count       (count),
        .drop_sticky (drop_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_fields();
        bus4a  = '0;
        bus4b  = '0;
        bus1a  = 1'b0;
        bus1b  = '0;
        busdef = '0;
    endtask

    task automatic test_reset();
        reset_l   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        clr_drop  = 1'b0;
        clear_fields();
        step();
        step();
        checks++; if (count !== 3'd0) $display("FAIL reset_count got %0d want 0", count); else passed++;
        checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else passed++;
        checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else passed++;
        checks++; if (drop_sticky !== 1'b0) $display("FAIL reset_drop got %b want 0", drop_sticky); else passed++;
        checks++; if (out_data !== 18'h0) $display("FAIL reset_out_data got %h want 0", out_data); else passed++;
        reset_l = 1'b1;
        step();
    endtask

    task automatic test_pack();
        bus4a     = 4'b1010;
        bus4b     = 4'hC;
        bus1a     = 1'b1;
        bus1b     = 1'b0;
        busdef    = 8'h5A;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        clear_fields();
        checks++; if (out_valid !== 1'b1) $display("FAIL pack_out_valid got %b want 1", out_valid); else passed++;
        checks++; if (out_data !== 18'h2B25A) $display("FAIL pack_data got %h want 2b25a", out_data); else passed++;
        checks++; if (count !== 3'd1) $display("FAIL pack_count got %0d want 1", count); else passed++;
        step();
        checks++; if (count !== 3'd0) $display("FAIL pack_drain_count got %0d want 0", count); else passed++;
        checks++; if (out_valid !== 1'b0) $display("FAIL pack_drain_valid got %b want 0", out_valid); else passed++;
        out_ready = 1'b0;
    endtask

    task automatic test_fill_full();
        out_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            busdef   = 8'(k);
            in_valid = 1'b1;
            if (k == 5) begin
                checks++; if (in_ready !== 1'b0) $display("FAIL fill_in_ready_5th got %b want 0", in_ready); else passed++;
            end
            step();
            if (k == 4) begin
                checks++; if (in_ready !== 1'b0) $display("FAIL fill_full_ready got %b want 0", in_ready); else passed++;
                checks++; if (count !== 3'd4) $display("FAIL fill_count got %0d want 4", count); else passed++;
                checks++; if (drop_sticky !== 1'b0) $display("FAIL fill_no_drop got %b want 0", drop_sticky); else passed++;
            end
        end
        in_valid = 1'b0;
        checks++; if (drop_sticky !== 1'b1) $display("FAIL fill_drop got %b want 1", drop_sticky); else passed++;
        checks++; if (count !== 3'd4) $display("FAIL fill_count_after_drop got %0d want 4", count); else passed++;
        out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            checks++; if (out_data !== 18'(k)) $display("FAIL drain_word%0d got %h want %h", k, out_data, 18'(k)); else passed++;
            step();
        end
        out_ready = 1'b0;
        checks++; if (count !== 3'd0) $display("FAIL drain_count got %0d want 0", count); else passed++;
        checks++; if (out_valid !== 1'b0) $display("FAIL drain_valid got %b want 0", out_valid); else passed++;
        clr_drop = 1'b1;
        step();
        clr_drop = 1'b0;
        checks++; if (drop_sticky !== 1'b0) $display("FAIL fill_clr got %b want 0", drop_sticky); else passed++;
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        busdef    = 8'd10;
        step();
        busdef = 8'd11;
        step();
        checks++; if (count !== 3'd2) $display("FAIL b2b_prefill got %0d want 2", count); else passed++;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            busdef = 8'(12 + i);
            checks++; if (out_data !== 18'(10 + i)) $display("FAIL b2b_data%0d got %h want %h", i, out_data, 18'(10 + i)); else passed++;
            step();
            checks++; if (count !== 3'd2) $display("FAIL b2b_count%0d got %0d want 2", i, count); else passed++;
        end
        in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++; if (out_data !== 18'(20 + i)) $display("FAIL b2b_tail%0d got %h want %h", i, out_data, 18'(20 + i)); else passed++;
            step();
        end
        out_ready = 1'b0;
        checks++; if (count !== 3'd0) $display("FAIL b2b_empty got %0d want 0", count); else passed++;
    endtask

    task automatic test_full_pop();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            busdef = 8'(30 + k);
            step();
        end
        busdef    = 8'd34;
        out_ready = 1'b1;
        checks++; if (in_ready !== 1'b0) $display("FAIL fullpop_ready got %b want 0", in_ready); else passed++;
        checks++; if (out_data !== 18'd30) $display("FAIL fullpop_head got %h want %h", out_data, 18'd30); else passed++;
        step();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checks++; if (count !== 3'd3) $display("FAIL fullpop_count got %0d want 3", count); else passed++;
        checks++; if (in_ready !== 1'b1) $display("FAIL fullpop_ready_next got %b want 1", in_ready); else passed++;
        checks++; if (drop_sticky !== 1'b1) $display("FAIL fullpop_drop got %b want 1", drop_sticky); else passed++;
        checks++; if (out_data !== 18'd31) $display("FAIL fullpop_next got %h want %h", out_data, 18'd31); else passed++;
        clr_drop = 1'b1;
        step();
        clr_drop = 1'b0;
        checks++; if (drop_sticky !== 1'b0) $display("FAIL fullpop_clr got %b want 0", drop_sticky); else passed++;
    endtask

    task automatic test_sticky_priority();
        // count is 3 here; one more push fills the FIFO
        busdef   = 8'd35;
        in_valid = 1'b1;
        step();
        checks++; if (count !== 3'd4) $display("FAIL sticky_full got %0d want 4", count); else passed++;
        busdef   = 8'd36;
        clr_drop = 1'b1;
        step();
        in_valid = 1'b0;
        checks++; if (drop_sticky !== 1'b1) $display("FAIL sticky_set_wins got %b want 1", drop_sticky); else passed++;
        step();
        clr_drop = 1'b0;
        checks++; if (drop_sticky !== 1'b0) $display("FAIL sticky_clear got %b want 0", drop_sticky); else passed++;
        checks++; if (count !== 3'd4) $display("FAIL sticky_count got %0d want 4", count); else passed++;
    endtask

    task automatic test_mid_reset();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++; if (count !== 3'd3) $display("FAIL midrst_pre got %0d want 3", count); else passed++;
        #2;
        reset_l = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) $display("FAIL midrst_valid got %b want 0", out_valid); else passed++;
        checks++; if (count !== 3'd0) $display("FAIL midrst_count got %0d want 0", count); else passed++;
        checks++; if (in_ready !== 1'b1) $display("FAIL midrst_ready got %b want 1", in_ready); else passed++;
        checks++; if (out_data !== 18'h0) $display("FAIL midrst_data got %h want 0", out_data); else passed++;
        reset_l = 1'b1;
        step();
        clear_fields();
        busdef   = 8'd1;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) $display("FAIL midrst_push_valid got %b want 1", out_valid); else passed++;
        checks++; if (out_data !== 18'h00001) $display("FAIL midrst_push_data got %h want 00001", out_data); else passed++;
        checks++; if (count !== 3'd1) $display("FAIL midrst_push_count got %0d want 1", count); else passed++;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++; if (count !== 3'd0) $display("FAIL midrst_final got %0d want 0", count); else passed++;
    endtask

    initial begin
        checks = 0;
        passed = 0;
        test_reset();
        test_pack();
        test_fill_full();
        test_back_to_back();
        test_full_pop();
        test_sticky_priority();
        test_mid_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
